// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer
// Buffers parallel words in a small FIFO and serialises each one as an
// asynchronous UART frame: start bit, data LSB first, optional parity bit,
// then one or two stop bits. Every output comes straight from a flop.
module uart_tx_packetizer #(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         data_in,
    input  logic                         data_valid,
    input  logic                         tx_ready,
    output logic                         serial_out,
    output logic                         tx_busy,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    // One bit counter serves both the data bits and the stop bits.
    localparam int NW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even parity makes the total count of ones even (plain XOR of the word);
    // odd parity is its complement.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        logic p;
        p = ^word;
        return (PARITY == 2) ? ~p : p;
    endfunction

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;

    logic push;
    logic pop;
    logic start_frame;

    // ------------------------------------------------------------------
    // Frame sequencer state
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [NW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;

    logic tick;
    logic last_data;
    logic last_stop;

    assign tick      = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign last_data = (bit_q == NW'(DATA_BITS - 1));
    assign last_stop = (bit_q == NW'(STOP_BITS - 1));

    // A frame may only be launched from IDLE; tx_ready is ignored elsewhere,
    // so dropping it mid-frame never truncates the frame in flight.
    assign start_frame = (state_q == S_IDLE) && !empty_q && tx_ready;

    // Fullness is judged on the registered flag, so a write into a full FIFO
    // is dropped even when the sequencer pops on the same edge.
    assign push = data_valid && !full_q;
    assign pop  = start_frame;

    // FIFO next-state: pointers, occupancy, flags and overflow pulse.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = data_valid && full_q;
    end

    // FIFO control flops; contents are left alone on reset since the
    // pointers alone decide what is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state: each state lasts whole bit periods, advancing on
    // the baud terminal count; PARITY is bypassed when parity is disabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_frame) state_d = S_START;
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick && last_data) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick && last_stop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Baud/bit counters, shift register and parity bit for the current frame.
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q == S_IDLE) begin
            baud_d = '0;
            bit_d  = '0;
            if (start_frame) begin
                shift_d = mem_q[rd_ptr_q];
                par_d   = parity_of(mem_q[rd_ptr_q]);
            end
        end else if (tick) begin
            baud_d = '0;
            // Bit count restarts whenever a new state begins.
            bit_d  = (state_d != state_q) ? '0 : bit_q + NW'(1);
            // Shift only between data bits; entering DATA presents bit 0 as is.
            if ((state_q == S_DATA) && (state_d == S_DATA)) begin
                shift_d = shift_q >> 1;
            end
        end else begin
            baud_d = baud_q + BW'(1);
        end
    end

    // Output decode from the next state so the line and busy flag are
    // registered yet change on the same edge as the state.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[0];
            S_PARITY: serial_d = par_d;
            default:  serial_d = 1'b1;
        endcase
    end

    // Control flops of the sequencer; reset drives the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q   <= '0;
            bit_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
        end
    end

    // Frame data flops; only meaningful while a frame is in flight.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Testbench for uart_tx_packetizer: three instances (no parity, even parity,
// odd parity with two stop bits) at 4 clocks per bit, a scoreboard of
// expected frames per instance and a line monitor per instance.
module tb_uart_tx_packetizer;

    localparam int CPB = 4;
    localparam int DEP = 4;

    typedef struct {
        logic [15:0] bits;   // bit k = k-th bit on the line
        int          nbits;
        int          gap;    // required idle cycles before the frame, -1 = any
        bit          trunc;  // frame is expected to be cut short by reset
    } frame_t;

    logic clk = 1'b0;
    logic rst;

    logic [7:0] din0, dinp;
    logic       dv0, dvp, rdy0, rdyp;

    logic       ser0, busy0, full0, empty0, ovf0;
    logic [2:0] cnt0;
    logic       ser1, busy1, full1, empty1, ovf1;
    logic [2:0] cnt1;
    logic       ser2, busy2, full2, empty2, ovf2;
    logic [2:0] cnt2;

    int checks = 0;
    int errors = 0;

    frame_t exp_q0[$];
    frame_t exp_q1[$];
    frame_t exp_q2[$];

    always #5 clk = ~clk;

    uart_tx_packetizer #(.DATA_BITS(8), .DEPTH(DEP), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv0), .tx_ready(rdy0),
        .serial_out(ser0), .tx_busy(busy0), .fifo_full(full0), .fifo_empty(empty0),
        .fifo_count(cnt0), .overflow(ovf0)
    );

    uart_tx_packetizer #(.DATA_BITS(8), .DEPTH(DEP), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(dinp), .data_valid(dvp), .tx_ready(rdyp),
        .serial_out(ser1), .tx_busy(busy1), .fifo_full(full1), .fifo_empty(empty1),
        .fifo_count(cnt1), .overflow(ovf1)
    );

    uart_tx_packetizer #(.DATA_BITS(8), .DEPTH(DEP), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(dinp), .data_valid(dvp), .tx_ready(rdyp),
        .serial_out(ser2), .tx_busy(busy2), .fifo_full(full2), .fifo_empty(empty2),
        .fifo_count(cnt2), .overflow(ovf2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [15:0] bits, input int nbits, input int gap, input bit trunc);
        frame_t f;
        f.bits  = bits;
        f.nbits = nbits;
        f.gap   = gap;
        f.trunc = trunc;
        return f;
    endfunction

    // 8N1 framing: start 0, byte LSB first, stop 1.
    function automatic logic [15:0] f8n1(input logic [7:0] b);
        return {6'b0, 1'b1, b, 1'b0};
    endfunction

    task automatic push_exp(input int idx, input frame_t f);
        case (idx)
            0:       exp_q0.push_back(f);
            1:       exp_q1.push_back(f);
            default: exp_q2.push_back(f);
        endcase
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic frame_t qpop(input int idx);
        case (idx)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic logic ser_of(input int idx);
        case (idx)
            0:       return ser0;
            1:       return ser1;
            default: return ser2;
        endcase
    endfunction

    function automatic logic busy_of(input int idx);
        case (idx)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    // Watches one line: every frame is matched against the head of that
    // instance's queue, bit by bit and cycle by cycle, followed by an idle cycle.
    task automatic run_monitor(input int idx);
        int          idle_cnt;
        frame_t      e;
        logic [15:0] got;
        bit          bad_t;
        bit          aborted;
        idle_cnt = 1000;
        forever begin
            @(negedge clk);
            if (rst) begin
                idle_cnt = 1000;
                continue;
            end
            if (!busy_of(idx)) begin
                idle_cnt++;
                continue;
            end
            chk($sformatf("frame_expected_%0d", idx), int'(qsize(idx) > 0), 1);
            if (qsize(idx) == 0) begin
                for (int k = 0; k < 200 && busy_of(idx); k++) @(negedge clk);
                idle_cnt = 0;
                continue;
            end
            e = qpop(idx);
            if (e.gap >= 0) chk($sformatf("idle_gap_%0d", idx), idle_cnt, e.gap);
            got     = '0;
            bad_t   = 1'b0;
            aborted = 1'b0;
            for (int c = 0; c < e.nbits * CPB; c++) begin
                if (c > 0) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (!busy_of(idx)) bad_t = 1'b1;
                if (c % CPB == 0) got[c / CPB] = ser_of(idx);
                else if (got[c / CPB] !== ser_of(idx)) bad_t = 1'b1;
            end
            if (aborted) begin
                chk($sformatf("truncation_expected_%0d", idx), int'(e.trunc), 1);
                idle_cnt = 1000;
                continue;
            end
            chk($sformatf("frame_bits_%0d", idx), int'(got), int'(e.bits));
            chk($sformatf("bit_timing_%0d", idx), int'(bad_t), 0);
            @(negedge clk);
            chk($sformatf("idle_after_frame_%0d", idx), int'({busy_of(idx), ser_of(idx)}), 1);
            idle_cnt = 1;
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);
    initial run_monitor(2);

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (!(qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0 && !busy0 && !busy1 && !busy2) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_within_budget", int'(n < maxc), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        din0 = '0;
        dinp = '0;
        dv0  = 1'b0;
        dvp  = 1'b0;
        rdy0 = 1'b0;
        rdyp = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_serial", int'(ser0), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_full", int'(full0), 0);
        chk("rst_empty", int'(empty0), 1);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_overflow", int'(ovf0), 0);
        chk("rst_serial_par", int'({ser1, ser2}), 3);
        #2 rst = 1'b0;

        // 0xA5 8N1, plus 0x3C with even and odd parity
        @(negedge clk);
        push_exp(0, mk(16'b0000_0011_0100_1010, 10, -1, 1'b0)); // line 0,1,0,1,0,0,1,0,1,1
        push_exp(1, mk({5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1, 1'b0));
        push_exp(2, mk({4'b0, 2'b11, 1'b1, 8'h3C, 1'b0}, 12, -1, 1'b0));
        rdy0 = 1'b1;
        dv0  = 1'b1;
        din0 = 8'hA5;
        dvp  = 1'b1;
        dinp = 8'h3C;
        @(negedge clk);
        dv0 = 1'b0;
        dvp = 1'b0;
        chk("wr_count", int'(cnt0), 1);
        chk("wr_empty", int'(empty0), 0);
        chk("wr_line_still_idle", int'(ser0), 1);
        @(negedge clk);
        chk("start_serial_low", int'(ser0), 0);
        chk("start_busy", int'(busy0), 1);
        chk("start_count_pop", int'(cnt0), 0);
        wait_drain(2000);

        // Fill with tx_ready low, one extra word overflows
        rdy0 = 1'b0;
        for (int i = 0; i < DEP + 1; i++) begin
            dv0  = 1'b1;
            din0 = 8'h11 * (i + 1);
            @(negedge clk);
            if (i == DEP - 1) begin
                chk("fill_full", int'(full0), 1);
                chk("fill_count", int'(cnt0), DEP);
                chk("fill_no_overflow_yet", int'(ovf0), 0);
            end
        end
        dv0 = 1'b0;
        chk("overflow_pulse", int'(ovf0), 1);
        chk("overflow_count_kept", int'(cnt0), DEP);
        chk("held_no_frame", int'(busy0), 0);
        @(negedge clk);
        chk("overflow_one_cycle", int'(ovf0), 0);
        push_exp(0, mk(f8n1(8'h11), 10, -1, 1'b0));
        push_exp(0, mk(f8n1(8'h22), 10, 1, 1'b0));
        push_exp(0, mk(f8n1(8'h33), 10, 1, 1'b0));
        push_exp(0, mk(f8n1(8'h44), 10, 1, 1'b0));
        rdy0 = 1'b1;
        wait_drain(2000);

        // Push and pop on the same edge with one entry held
        push_exp(0, mk(f8n1(8'h66), 10, -1, 1'b0));
        push_exp(0, mk(f8n1(8'h77), 10, 1, 1'b0));
        rdy0 = 1'b0;
        dv0  = 1'b1;
        din0 = 8'h66;
        @(negedge clk);
        chk("one_entry_count", int'(cnt0), 1);
        rdy0 = 1'b1;
        din0 = 8'h77;
        @(negedge clk);
        dv0 = 1'b0;
        chk("push_pop_count", int'(cnt0), 1);
        chk("push_pop_busy", int'(busy0), 1);
        wait_drain(2000);

        // Push while full with a same-edge pop, then tx_ready dropped mid-frame
        push_exp(0, mk(f8n1(8'h90), 10, -1, 1'b0));
        push_exp(0, mk(f8n1(8'h91), 10, -1, 1'b0));
        push_exp(0, mk(f8n1(8'h92), 10, 1, 1'b0));
        push_exp(0, mk(f8n1(8'h93), 10, 1, 1'b0));
        rdy0 = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            dv0  = 1'b1;
            din0 = 8'h90 + 8'(i);
            @(negedge clk);
        end
        chk("full_before_pop", int'(full0), 1);
        rdy0 = 1'b1;
        din0 = 8'hEE;
        @(negedge clk);
        dv0  = 1'b0;
        rdy0 = 1'b0;
        chk("full_pop_count", int'(cnt0), DEP - 1);
        chk("full_pop_flag", int'(full0), 0);
        chk("full_pop_overflow", int'(ovf0), 1);
        chk("full_pop_busy", int'(busy0), 1);
        repeat (60) @(negedge clk);
        chk("ready_low_no_start", int'(busy0), 0);
        chk("ready_low_count", int'(cnt0), DEP - 1);
        chk("ready_low_line", int'(ser0), 1);
        rdy0 = 1'b1;
        wait_drain(2000);

        // Reset during the data bits of 0x5A with 0xC3 still queued
        push_exp(0, mk(f8n1(8'h5A), 10, -1, 1'b1));
        dv0  = 1'b1;
        din0 = 8'h5A;
        @(negedge clk);
        din0 = 8'hC3;
        @(negedge clk);
        dv0 = 1'b0;
        chk("pre_rst_count", int'(cnt0), 1);
        chk("pre_rst_empty", int'(empty0), 0);
        chk("pre_rst_busy", int'(busy0), 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_serial", int'(ser0), 1);
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_empty", int'(empty0), 1);
        chk("mid_rst_count", int'(cnt0), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        push_exp(0, mk(16'b0000_0011_0000_0010, 10, -1, 1'b0)); // 0x81: line 0,1,0,0,0,0,0,0,1,1
        dv0  = 1'b1;
        din0 = 8'h81;
        @(negedge clk);
        dv0 = 1'b0;
        wait_drain(2000);

        chk("queue0_consumed", qsize(0), 0);
        chk("queue1_consumed", qsize(1), 0);
        chk("queue2_consumed", qsize(2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
